level_generator: RTL and testbench
==================================

LEVEL_GENERATOR -- requirements
Module: level_generator

Interface
REQ-001 SHALL have parameter HIGH_CYCLES, default 3: clocks `level` is held high per accepted tick (legal range 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 2: minimum low clocks after each high phase (legal range 1..255).
REQ-003 SHALL have port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port `tick`, input, 1 bit: single-cycle request pulse, as emitted by the team's edge-detect counters.
REQ-006 SHALL have port `level`, output, 1 bit: registered generated level waveform.
REQ-007 SHALL have port `busy`, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have port `dropped`, output, 1 bit: one-cycle registered pulse when a tick is discarded.
REQ-009 SHALL have port `level_count`, output, 3 bits: count of completed high phases, modulo 5.
REQ-010 SHALL have port `state_out`, output, 2 bits: current state encoding, for debug.

Function
REQ-011 SHALL implement states IDLE=0, HIGH=1, GAP=2; encoding 3 is unreachable and SHALL recover to IDLE on the next clock.
REQ-012 In IDLE with `tick`=1, the FSM SHALL enter HIGH on that edge, so `level` is 1 in the following cycle (one-cycle latency).
REQ-013 HIGH SHALL last exactly HIGH_CYCLES clocks with `level`=1, then the FSM SHALL enter GAP.
REQ-014 GAP SHALL last exactly GAP_CYCLES clocks with `level`=0, then the FSM SHALL enter IDLE, or HIGH if a pending tick exists (REQ-022).
REQ-015 `level_count` SHALL increment on each HIGH->GAP transition and wrap 4->0.
REQ-016 A tick sampled while `busy`=1 and not queued SHALL assert `dropped` for exactly one cycle, next clock.
REQ-017 A tick in the final GAP cycle SHALL be treated as busy (not accepted directly).
REQ-018 `tick` held high for multiple cycles SHALL be treated as one tick per sampled cycle.
REQ-019 The phase timer SHALL be 8 bits wide, counting down, and never underflow.

Reset
REQ-020 While `reset`=1 at a clock edge: state=IDLE, `level`=0, `busy`=0, `dropped`=0, `level_count`=0, `state_out`=0, timer=0, pending=0.
REQ-021 Reset asserted mid-HIGH or mid-GAP SHALL abort the phase immediately, with no `level_count` increment and no `dropped` pulse.

Configuration
REQ-022 With macro LEVEL_GEN_QUEUE_EN defined: a one-deep pending flag SHALL capture the first tick while busy, without asserting `dropped`. Further ticks while pending is set SHALL be dropped (REQ-016). At GAP end with pending set, the FSM SHALL go directly to HIGH and clear pending.
REQ-023 Without LEVEL_GEN_QUEUE_EN: no pending flag; every tick while busy SHALL be dropped.

Structure
REQ-024 Package level_gen_pkg SHALL hold the state typedef/encodings, the timer width constant (8), and the modulus constant (5).
REQ-025 Sub-module level_timer (loadable 8-bit down-counter with a `done` flag) SHALL time both phases. The FSM, pending flag and counters SHALL stay in level_generator.

Verification (HIGH_CYCLES=3, GAP_CYCLES=2, clock period 20)
REQ-026 Reset, then one tick -> `level`=1 for exactly 3 cycles starting the cycle after the tick, then 0; `busy` high for 5 cycles; `level_count`=1.
REQ-027 Five ticks spaced 8 cycles apart -> `level_count` sequence 1,2,3,4,0; no `dropped` pulses.
REQ-028 Tick, then a second tick 2 cycles later -> without macro, one `dropped` pulse and one high phase; with macro, no `dropped` and a second high phase starting immediately after GAP.
REQ-029 With macro: three ticks in consecutive busy cycles -> first queued, second and third each produce a `dropped` pulse.
REQ-030 `reset` pulsed in the 2nd HIGH cycle -> `level`=0 and state IDLE the next cycle; `level_count` unchanged from 0.

Source files
------------

// File: rtl/level_gen_pkg.sv
// Shared types and constants for the level generator slice.
// State encoding, phase-timer width and the completed-phase counter modulus.
package level_gen_pkg;

  localparam int unsigned TIMER_W   = 8;
  localparam int unsigned LEVEL_MOD = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'(LEVEL_MOD - 1)) ? '0 : v + 3'd1;
  endfunction

endpackage

// File: rtl/level_timer.sv
// Loadable down-counter that times the HIGH and GAP phases.
// Saturates at zero; done is asserted while the count is zero.
module level_timer
  import level_gen_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               dec,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/level_generator.sv
// Converts tick pulses into HIGH_CYCLES-long level pulses separated by GAP_CYCLES.
// Define LEVEL_GEN_QUEUE_EN to hold one tick that arrives while busy.
module level_generator
  import level_gen_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = 3,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  output logic       level,
  output logic       busy,
  output logic       dropped,
  output logic [2:0] level_count,
  output logic [1:0] state_out
);

  // The timer is loaded with N-1 so a phase spans exactly N clocks.
  localparam logic [TIMER_W-1:0] HIGH_LOAD = TIMER_W'(HIGH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);

  state_t             state;
  logic               timer_load;
  logic               timer_dec;
  logic               timer_done;
  logic [TIMER_W-1:0] timer_value;
  logic               pending;
  logic               take_queue;
  logic               resume;

  assign busy      = (state != ST_IDLE);
  assign state_out = state;

`ifdef LEVEL_GEN_QUEUE_EN
  assign take_queue = tick & busy & ~pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
    end else if ((state == ST_GAP) && timer_done) begin
      pending <= 1'b0;
    end else if (take_queue) begin
      pending <= 1'b1;
    end
  end
`else
  assign take_queue = 1'b0;
  assign pending    = 1'b0;
`endif

  // A tick captured in the final GAP cycle is consumed on the same edge.
  assign resume = pending | take_queue;

  always_comb begin
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    timer_value = '0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          timer_load  = 1'b1;
          timer_value = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (timer_done) begin
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_done) begin
          if (resume) begin
            timer_load  = 1'b1;
            timer_value = HIGH_LOAD;
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  level_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .done       (timer_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      level       <= 1'b0;
      dropped     <= 1'b0;
      level_count <= '0;
    end else begin
      dropped <= tick & busy & ~take_queue;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_HIGH;
            level <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (timer_done) begin
            state       <= ST_GAP;
            level       <= 1'b0;
            level_count <= wrap_inc(level_count);
          end
        end
        ST_GAP: begin
          if (timer_done) begin
            if (resume) begin
              state <= ST_HIGH;
              level <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_generator.sv
// Self-checking bench for level_generator: a behavioural model pushes expected
// outputs per clock; they are popped and compared one step after each edge.
module tb_level_generator;

  localparam int unsigned HIGH_CYCLES = 3;
  localparam int unsigned GAP_CYCLES  = 2;
`ifdef LEVEL_GEN_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic       level;
  logic       busy;
  logic       dropped;
  logic [2:0] level_count;
  logic [1:0] state_out;

  level_generator #(
    .HIGH_CYCLES (HIGH_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .level       (level),
    .busy        (busy),
    .dropped     (dropped),
    .level_count (level_count),
    .state_out   (state_out)
  );

  always #10 clock = ~clock;

  typedef struct {
    int lvl;
    int bsy;
    int drp;
    int cnt;
    int st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_st   = 0;
  int m_rem  = 0;
  int m_pend = 0;
  int m_cnt  = 0;

  int lvl_cycles;
  int busy_cycles;
  int drops;
  int rises;
  int prev_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Model counts remaining clocks in the current phase, including the present one.
  task automatic model_edge(input logic r, input logic t);
    exp_t e;
    int drop, was_busy, q_take;
    drop = 0;
    if (r) begin
      m_st = 0; m_rem = 0; m_pend = 0; m_cnt = 0;
    end else begin
      was_busy = (m_st != 0) ? 1 : 0;
      q_take   = (QEN && was_busy == 1 && t && m_pend == 0) ? 1 : 0;
      if (was_busy == 1 && t && q_take == 0) drop = 1;
      if (q_take == 1) m_pend = 1;
      case (m_st)
        0: if (t) begin m_st = 1; m_rem = HIGH_CYCLES; end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_st = 2; m_rem = GAP_CYCLES; m_cnt = (m_cnt + 1) % 5;
          end
        end
        2: begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_pend == 1) begin m_st = 1; m_rem = HIGH_CYCLES; m_pend = 0; end
            else m_st = 0;
          end
        end
        default: m_st = 0;
      endcase
    end
    e.lvl = (m_st == 1) ? 1 : 0;
    e.bsy = (m_st != 0) ? 1 : 0;
    e.drp = drop;
    e.cnt = m_cnt;
    e.st  = m_st;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic t);
    exp_t e;
    reset = r;
    tick  = t;
    @(posedge clock);
    model_edge(r, t);
    #1;
    e = sb.pop_front();
    check("level", 32'(level), e.lvl);
    check("busy", 32'(busy), e.bsy);
    check("dropped", 32'(dropped), e.drp);
    check("level_count", 32'(level_count), e.cnt);
    check("state_out", 32'(state_out), e.st);
    if (level) lvl_cycles++;
    if (busy) busy_cycles++;
    if (dropped) drops++;
    if (level && prev_lvl == 0) rises++;
    prev_lvl = level ? 1 : 0;
  endtask

  task automatic clear_stats();
    lvl_cycles = 0; busy_cycles = 0; drops = 0; rises = 0; prev_lvl = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    clear_stats();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // single tick
    clear_stats();
    step(1'b0, 1'b1);
    idle(8);
    check("single_level_cycles", lvl_cycles, 3);
    check("single_busy_cycles", busy_cycles, 5);
    check("single_count", 32'(level_count), 1);

    // five spaced ticks, count wraps to 0
    step(1'b1, 1'b0);
    clear_stats();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1);
      idle(7);
    end
    check("spaced_drops", drops, 0);
    check("spaced_rises", rises, 5);
    check("spaced_wrap_count", 32'(level_count), 0);

    // second tick two cycles after the first
    step(1'b1, 1'b0);
    clear_stats();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    idle(12);
    check("overlap_drops", drops, QEN ? 0 : 1);
    check("overlap_rises", rises, QEN ? 2 : 1);

    // tick held through three busy cycles
    step(1'b1, 1'b0);
    clear_stats();
    step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    idle(14);
    check("burst_drops", drops, QEN ? 2 : 3);

    // tick landing in the final GAP cycle
    step(1'b1, 1'b0);
    clear_stats();
    step(1'b0, 1'b1);
    idle(4);
    step(1'b0, 1'b1);
    idle(10);
    check("final_gap_rises", rises, QEN ? 2 : 1);

    // reset in the second HIGH cycle
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("abort_level", 32'(level), 0);
    check("abort_state", 32'(state_out), 0);
    check("abort_count", 32'(level_count), 0);

    // random traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
